// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port DLX register file: width defaults,
// controller state encoding and the hardwired-zero register test.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic logic zero_reg(input logic [31:0] addr);
    return (addr == 32'd0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode issue and
// cleared by writeback commit, with a combinational busy lookup per read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      issue_en,
  input  logic [AW-1:0]             issue_rd,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [NREAD-1:0][AW-1:0]  rd_addr,
  output logic [NREAD-1:0]          busy
);

  logic [NREGS-1:0] pending_r;
  logic [NREGS-1:0] pending_next_s;

  // Next pending vector; a same-cycle issue beats the commit since a newer producer is in flight
  always_comb begin
    pending_next_s = pending_r;
    for (int r = 0; r < NREGS; r++) begin
      if (issue_en && (issue_rd == AW'(r))) begin
        pending_next_s[r] = 1'b1;
      end else if (wr_en && (wr_addr == AW'(r))) begin
        pending_next_s[r] = 1'b0;
      end else begin
        pending_next_s[r] = pending_r[r];
      end
    end
    pending_next_s[0] = 1'b0;
  end

  // Pending vector register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_next_s;
    end
  end

  // Busy lookup; a commit to the same register this cycle is forwarded, so it is not busy
  always_comb begin
    busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (run && !zero_reg(32'(rd_addr[i])) && pending_r[rd_addr[i]] &&
          !(wr_en && (wr_addr == rd_addr[i]))) begin
        busy[i] = 1'b1;
      end else begin
        busy[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port DLX register file: post-reset clear sweep, registered reads with
// write-to-read bypass, and a pending-write scoreboard for hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ready,
  input  logic [NREAD-1:0]           rd_en,
  input  logic [NREAD-1:0][AW-1:0]   rd_addr,
  output logic [NREAD-1:0][XLEN-1:0] rd_data,
  output logic [NREAD-1:0]           busy,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [XLEN-1:0]            wr_data,
  input  logic                       issue_en,
  input  logic [AW-1:0]              issue_rd
);

  state_t                    state_r;
  state_t                    next_state_s;
  logic [AW-1:0]             idx_r;
  logic [XLEN-1:0]           regs_r [NREGS];
  logic                      run_s;
  logic                      wr_ok_s;
  logic                      issue_ok_s;
  logic [NREAD-1:0][XLEN-1:0] rd_value_s;

  assign run_s      = (state_r == RUN);
  assign wr_ok_s    = run_s && wr_en && !zero_reg(32'(wr_addr));
  assign issue_ok_s = run_s && issue_en && !zero_reg(32'(issue_rd));

  // Next-state logic; idx wraps to 0 after the last register is cleared
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      CLEAR: begin
        if (idx_r == '0) begin
          next_state_s = RUN;
        end else begin
          next_state_s = CLEAR;
        end
      end
      RUN:     next_state_s = RUN;
      default: next_state_s = CLEAR;
    endcase
  end

  // State, sweep index and ready registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= CLEAR;
      idx_r   <= AW'(1);
      ready   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready   <= (next_state_s == RUN);
      if ((state_r == CLEAR) && (idx_r != '0)) begin
        idx_r <= idx_r + AW'(1);
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Register array: the sweep owns the write port until RUN
  always_ff @(posedge clk) begin
    if (!run_s && (idx_r != '0)) begin
      regs_r[idx_r] <= '0;
    end else if (wr_ok_s) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Per-port read value with same-cycle writeback forwarding
  always_comb begin
    rd_value_s = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (zero_reg(32'(rd_addr[i]))) begin
        rd_value_s[i] = '0;
      end else if (wr_ok_s && (wr_addr == rd_addr[i])) begin
        rd_value_s[i] = wr_data;
      end else begin
        rd_value_s[i] = regs_r[rd_addr[i]];
      end
    end
  end

  // Read data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      for (int i = 0; i < NREAD; i++) begin
        if (!run_s) begin
          rd_data[i] <= '0;
        end else if (rd_en[i]) begin
          rd_data[i] <= rd_value_s[i];
        end else begin
          rd_data[i] <= rd_data[i];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .run      (run_s),
    .issue_en (issue_ok_s),
    .issue_rd (issue_rd),
    .wr_en    (wr_ok_s),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .busy     (busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters
// (XLEN=32, NREGS=32, NREAD=2); expected values are hand-computed constants.
module tb_regfile_mp;

  logic             clk;
  logic             reset;
  logic             ready;
  logic [1:0]       rd_en;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0]       busy;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             issue_en;
  logic [4:0]       issue_rd;

  int checks;
  int failures;

  regfile_mp dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .issue_en (issue_en),
    .issue_rd (issue_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en    = 2'b00;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 32'd0;
    issue_en = 1'b0;
    issue_rd = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) tick();
    checks++;
    if (ready !== 1'b0 || rd_data !== 64'd0 || busy !== 2'b00) begin
      failures++;
      $display("FAIL reset_state: ready=%b rd_data=%h busy=%b expected 0/0/0", ready, rd_data, busy);
    end
    reset = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      checks++;
      if (ready !== (e == 32)) begin
        failures++;
        $display("FAIL reset_sweep_ready edge %0d: got %b expected %b", e, ready, (e == 32));
      end
    end
    for (int r = 0; r < 32; r += 2) begin
      rd_en      = 2'b11;
      rd_addr[0] = 5'(r);
      rd_addr[1] = 5'(r + 1);
      tick();
      checks++;
      if (rd_data !== 64'd0) begin
        failures++;
        $display("FAIL sweep_zero r%0d/r%0d: got %h expected 0", r, r + 1, rd_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    rd_en      = 2'b11;
    rd_addr[0] = 5'd5;
    rd_addr[1] = 5'd3;
    tick();
    checks++;
    if (rd_data[0] !== 32'hDEADBEEF || rd_data[1] !== 32'd0) begin
      failures++;
      $display("FAIL write_read: got %h/%h expected deadbeef/0", rd_data[0], rd_data[1]);
    end
    rd_en      = 2'b00;
    rd_addr[0] = 5'd3;
    tick();
    checks++;
    if (rd_data[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_hold: got %h expected deadbeef", rd_data[0]);
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    wr_en      = 1'b1;
    wr_addr    = 5'd7;
    wr_data    = 32'h12345678;
    rd_en      = 2'b11;
    rd_addr[0] = 5'd7;
    rd_addr[1] = 5'd7;
    tick();
    checks++;
    if (rd_data[0] !== 32'h12345678 || rd_data[1] !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass: got %h/%h expected 12345678 on both", rd_data[0], rd_data[1]);
    end
    wr_addr    = 5'd0;
    wr_data    = 32'hFFFFFFFF;
    rd_en      = 2'b01;
    rd_addr[0] = 5'd0;
    tick();
    checks++;
    if (rd_data[0] !== 32'd0 || rd_data[1] !== 32'h12345678) begin
      failures++;
      $display("FAIL r0_bypass: got %h/%h expected 0/12345678", rd_data[0], rd_data[1]);
    end
    wr_en      = 1'b0;
    rd_en      = 2'b10;
    rd_addr[1] = 5'd0;
    tick();
    checks++;
    if (rd_data[1] !== 32'd0) begin
      failures++;
      $display("FAIL r0_read: got %h expected 0", rd_data[1]);
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    issue_en = 1'b1;
    issue_rd = 5'd9;
    tick();
    issue_en   = 1'b0;
    rd_addr[0] = 5'd9;
    rd_addr[1] = 5'd8;
    #1;
    checks++;
    if (busy !== 2'b01) begin
      failures++;
      $display("FAIL busy_issue: got %b expected 01", busy);
    end
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h99;
    #1;
    checks++;
    if (busy !== 2'b00) begin
      failures++;
      $display("FAIL busy_same_cycle_wr: got %b expected 00", busy);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (busy !== 2'b00) begin
      failures++;
      $display("FAIL busy_after_wr: got %b expected 00", busy);
    end
    issue_en = 1'b1;
    issue_rd = 5'd4;
    wr_en    = 1'b1;
    wr_addr  = 5'd4;
    wr_data  = 32'h44;
    tick();
    issue_en = 1'b1;
    issue_rd = 5'd12;
    wr_en    = 1'b1;
    wr_addr  = 5'd9;
    tick();
    issue_en   = 1'b0;
    wr_en      = 1'b0;
    rd_addr[0] = 5'd4;
    rd_addr[1] = 5'd12;
    #1;
    checks++;
    if (busy !== 2'b11) begin
      failures++;
      $display("FAIL busy_set_wins: got %b expected 11", busy);
    end
    issue_en = 1'b1;
    issue_rd = 5'd0;
    tick();
    issue_en   = 1'b0;
    rd_addr[0] = 5'd0;
    rd_addr[1] = 5'd9;
    #1;
    checks++;
    if (busy !== 2'b00) begin
      failures++;
      $display("FAIL busy_r0_and_diff_reg_wr: got %b expected 00", busy);
    end
    wr_en   = 1'b1;
    wr_addr = 5'd4;
    tick();
    wr_addr = 5'd12;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    wr_en    = 1'b1;
    wr_addr  = 5'd10;
    wr_data  = 32'hA5A5A5A5;
    issue_en = 1'b1;
    issue_rd = 5'd11;
    tick();
    idle_inputs();
    rd_addr[0] = 5'd11;
    #1;
    checks++;
    if (busy !== 2'b01) begin
      failures++;
      $display("FAIL mid_busy_before_reset: got %b expected 01", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || busy !== 2'b00 || rd_data !== 64'd0) begin
      failures++;
      $display("FAIL mid_async_reset: ready=%b busy=%b rd_data=%h expected 0/00/0", ready, busy, rd_data);
    end
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      checks++;
      if (ready !== (e == 32)) begin
        failures++;
        $display("FAIL mid_sweep_ready edge %0d: got %b expected %b", e, ready, (e == 32));
      end
    end
    #1;
    checks++;
    if (busy !== 2'b00) begin
      failures++;
      $display("FAIL mid_pending_cleared: got %b expected 00", busy);
    end
    rd_en      = 2'b01;
    rd_addr[0] = 5'd10;
    wr_en      = 1'b1;
    wr_addr    = 5'd10;
    wr_data    = 32'h0BADF00D;
    tick();
    wr_en      = 1'b0;
    rd_en      = 2'b10;
    rd_addr[1] = 5'd10;
    tick();
    rd_en = 2'b00;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      checks++;
      if (ready !== (e == 32)) begin
        failures++;
        $display("FAIL resweep_ready edge %0d: got %b expected %b", e, ready, (e == 32));
      end
    end
    rd_en      = 2'b11;
    rd_addr[0] = 5'd10;
    rd_addr[1] = 5'd5;
    tick();
    checks++;
    if (rd_data !== 64'd0) begin
      failures++;
      $display("FAIL resweep_r10_r5_zero: got %h expected 0", rd_data);
    end
    idle_inputs();
  endtask

  task automatic test_clear_ignored();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr_en      = 1'b1;
    wr_addr    = 5'd2;
    wr_data    = 32'h55;
    issue_en   = 1'b1;
    issue_rd   = 5'd2;
    rd_en      = 2'b11;
    rd_addr[0] = 5'd2;
    rd_addr[1] = 5'd2;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e < 32) begin
        checks++;
        if (rd_data !== 64'd0 || busy !== 2'b00) begin
          failures++;
          $display("FAIL clear_ignore edge %0d: rd_data=%h busy=%b expected 0/00", e, rd_data, busy);
        end
      end
    end
    idle_inputs();
    rd_en      = 2'b01;
    rd_addr[0] = 5'd2;
    #1;
    checks++;
    if (ready !== 1'b1 || busy !== 2'b00) begin
      failures++;
      $display("FAIL clear_ignore_after: ready=%b busy=%b expected 1/00", ready, busy);
    end
    tick();
    checks++;
    if (rd_data[0] !== 32'd0) begin
      failures++;
      $display("FAIL clear_ignore_r2: got %h expected 0", rd_data[0]);
    end
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_reset_mid();
    test_clear_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
